// File: rtl/spi_pkg.sv
// spi_pkg: shared types and widths for the LCD SPI receive path.
// FSM encoding, byte/word widths and the D/C bit position.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } state_t;

    localparam int SPI_BYTE_W = 8;
    localparam int RX_WORD_W  = 9;
    localparam int DC_BIT     = 8;

endpackage

// File: rtl/spi_lcd_rx_if.sv
// spi_lcd_rx_if: SPI pins plus the downstream FIFO write port.
// master drives the SPI lines and FIFO status, slave is the receiver.
interface spi_lcd_rx_if;
    import spi_pkg::*;

    logic                 spi_lcd_csn;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_datacommand;
    logic                 rx_full;
    logic                 rx_wr;
    logic [RX_WORD_W-1:0] rx_dout;

    modport master (
        output spi_lcd_csn,
        output spi_clk,
        output spi_mosi,
        output spi_datacommand,
        output rx_full,
        input  rx_wr,
        input  rx_dout
    );

    modport slave (
        input  spi_lcd_csn,
        input  spi_clk,
        input  spi_mosi,
        input  spi_datacommand,
        input  rx_full,
        output rx_wr,
        output rx_dout
    );

endinterface

// File: rtl/spi_sync.sv
// spi_sync: N-flop synchroniser for one asynchronous SPI input.
// RESET_VAL sets the idle level presented while in reset.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // shift the raw input through the flop chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= {SYNC_STAGES{RESET_VAL}};
        else      ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: SPI mode-0 responder for the LCD command link.
// Deserialises MSB-first bytes tagged with D/C into a 9-bit FIFO stream.
module spi_lcd_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    spi_lcd_rx_if.slave      bus,
    input  logic             err_clr,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] rx_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic csn_s, sclk_s, mosi_s, dc_s, sync_ready;
    logic sclk_prev, rise_q, bit_q, dc_q, armed;

    state_t state, state_nxt;

    logic [SPI_BYTE_W-2:0] shr, shr_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [RX_WORD_W-1:0]  dout_nxt;
    logic                  wr_nxt, ovr_set, ferr_set, count_inc;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .d(bus.spi_lcd_csn), .q(csn_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(bus.spi_clk), .q(sclk_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(bus.spi_mosi), .q(mosi_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
        .clk(clk), .rst(rst), .d(bus.spi_datacommand), .q(dc_s)
    );
    // goes high once the synchronisers hold real samples, not reset values
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ready (
        .clk(clk), .rst(rst), .d(1'b1), .q(sync_ready)
    );

    assign busy = ~csn_s;

    // registered SCLK rise with the MOSI/DC samples taken alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev <= 1'b0;
            rise_q    <= 1'b0;
            bit_q     <= 1'b0;
            dc_q      <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            rise_q    <= sclk_s & ~sclk_prev;
            bit_q     <= mosi_s;
            dc_q      <= dc_s;
        end
    end

    // a CS already low at reset release must go high before a frame starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b0;
        else      armed <= armed | (sync_ready & csn_s);
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (armed && !csn_s) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (csn_s)                       state_nxt = IDLE;
                else if (rise_q && cnt == 3'd7)  state_nxt = PUSH;
            end
            PUSH: begin
                state_nxt = csn_s ? IDLE : SHIFT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath and output decode per state
    always_comb begin
        shr_nxt   = shr;
        cnt_nxt   = cnt;
        dout_nxt  = bus.rx_dout;
        wr_nxt    = 1'b0;
        ovr_set   = 1'b0;
        ferr_set  = 1'b0;
        count_inc = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                shr_nxt = '0;
            end
            SHIFT: begin
                if (csn_s) begin
                    ferr_set = (cnt != 3'd0);
                    cnt_nxt  = 3'd0;
                    shr_nxt  = '0;
                end else if (rise_q) begin
                    shr_nxt = {shr[SPI_BYTE_W-3:0], bit_q};
                    cnt_nxt = cnt + 3'd1;
                    if (cnt == 3'd7) dout_nxt = {dc_q, shr, bit_q};
                end
            end
            PUSH: begin
                wr_nxt    = ~bus.rx_full;
                count_inc = ~bus.rx_full;
                ovr_set   = bus.rx_full;
            end
            default: ;
        endcase
    end

    // output registers, counters and sticky flags (set beats clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shr         <= '0;
            cnt         <= 3'd0;
            bus.rx_dout <= '0;
            bus.rx_wr   <= 1'b0;
            rx_count    <= '0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            shr         <= shr_nxt;
            cnt         <= cnt_nxt;
            bus.rx_dout <= dout_nxt;
            bus.rx_wr   <= wr_nxt;
            if (count_inc) rx_count <= rx_count + CNT_ONE;
            overrun     <= ovr_set | (overrun & ~err_clr);
            frame_err   <= ferr_set | (frame_err & ~err_clr);
        end
    end

endmodule
